wb_ram_arbiter_2m: RTL and testbench

Two-master Wishbone B3 arbiter sharing one 32-bit single-port synchronous RAM slave between the OR10 instruction bus (m0) and data bus (m1). It grants whole Wishbone cycles with round-robin priority and routes the slave's ack/err back to the owner. A watchdog terminates a stalled access with an error. It sits directly in front of the RAM in the memory subsystem.

---
 rtl/wb_ram_arbiter_2m.sv | 134 +++++++++++++
 tb/tb_wb_ram_arbiter_2m.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_ram_arbiter_2m.sv
// Two-master Wishbone B3 arbiter in front of a single-port RAM slave.
// Grants whole cycles round-robin and terminates a stalled strobe with err via a watchdog.
module wb_ram_arbiter_2m #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TIMEOUT_WIDTH  = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,

    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_adr_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,

    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_adr_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,

    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [31:0] s_adr_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_dat_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_err_i
);

    typedef enum logic [1:0] {StIdle, StGrant0, StGrant1} state_e;

    localparam logic [TIMEOUT_WIDTH-1:0] WdLimit  = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [TIMEOUT_WIDTH-1:0] WdMax    = '1;
    localparam bit                       WdEnable = (TIMEOUT_CYCLES != 0);

    state_e                   state_q, state_d;
    logic                     last_q, last_d;
    logic [TIMEOUT_WIDTH-1:0] wd_q, wd_d;
    logic                     owner_stb;
    logic                     force_err;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
        end
    end

    always_comb begin
        owner_stb = 1'b0;
        case (state_q)
            StGrant0: owner_stb = m0_stb_i;
            StGrant1: owner_stb = m1_stb_i;
            default:  owner_stb = 1'b0;
        endcase
        force_err = WdEnable && (wd_q == WdLimit) && owner_stb && !s_ack_i && !s_err_i;
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        wd_d    = '0;
        case (state_q)
            StIdle: begin
                // On a tie the master that was not granted last wins.
                if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
                    state_d = StGrant0;
                    last_d  = 1'b0;
                end else if (m1_cyc_i) begin
                    state_d = StGrant1;
                    last_d  = 1'b1;
                end
            end
            StGrant0: if (!m0_cyc_i) state_d = StIdle;
            StGrant1: if (!m1_cyc_i) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        if (owner_stb && !s_ack_i && !s_err_i) begin
            wd_d = (wd_q == WdMax) ? wd_q : wd_q + 1'b1;
        end
    end

    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = m0_we_i;
        s_adr_o  = m0_adr_i;
        s_sel_o  = m0_sel_i;
        s_dat_o  = m0_dat_i;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        case (state_q)
            StGrant0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i & !force_err;
                m0_ack_o = s_ack_i;
                m0_err_o = s_err_i | force_err;
            end
            StGrant1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i & !force_err;
                s_we_o   = m1_we_i;
                s_adr_o  = m1_adr_i;
                s_sel_o  = m1_sel_i;
                s_dat_o  = m1_dat_i;
                m1_ack_o = s_ack_i;
                m1_err_o = s_err_i | force_err;
            end
            default: ;
        endcase
    end

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_wb_ram_arbiter_2m.sv
// Self-checking bench for wb_ram_arbiter_2m with a behavioural single-cycle RAM slave
// and per-master read-data scoreboards.
module tb_wb_ram_arbiter_2m;

    localparam logic [31:0] BadAdr = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
    logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
    logic [3:0]  m0_sel_i, m1_sel_i;
    logic [31:0] m0_dat_o, m1_dat_o;
    logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [31:0] s_adr_o, s_dat_o, s_dat_i;
    logic [3:0]  s_sel_o;
    logic        s_ack_i, s_err_i;

    logic [31:0] ram [64];
    logic [31:0] exp_mem [64];
    logic [31:0] rdat_q;
    logic        ack_q, err_q, ack_en, ram_load;
    logic [31:0] sb0 [$];
    logic [31:0] sb1 [$];
    int          n_assert = 0;
    int          n_fail = 0;
    int          cyc_cnt = 0;

    always #5 clk = ~clk;

    wb_ram_arbiter_2m #(
        .TIMEOUT_CYCLES(4),
        .TIMEOUT_WIDTH (3)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_n_i(rst_n),
        .m0_cyc_i  (m0_cyc_i),
        .m0_stb_i  (m0_stb_i),
        .m0_we_i   (m0_we_i),
        .m0_adr_i  (m0_adr_i),
        .m0_sel_i  (m0_sel_i),
        .m0_dat_i  (m0_dat_i),
        .m0_dat_o  (m0_dat_o),
        .m0_ack_o  (m0_ack_o),
        .m0_err_o  (m0_err_o),
        .m1_cyc_i  (m1_cyc_i),
        .m1_stb_i  (m1_stb_i),
        .m1_we_i   (m1_we_i),
        .m1_adr_i  (m1_adr_i),
        .m1_sel_i  (m1_sel_i),
        .m1_dat_i  (m1_dat_i),
        .m1_dat_o  (m1_dat_o),
        .m1_ack_o  (m1_ack_o),
        .m1_err_o  (m1_err_o),
        .s_cyc_o   (s_cyc_o),
        .s_stb_o   (s_stb_o),
        .s_we_o    (s_we_o),
        .s_adr_o   (s_adr_o),
        .s_sel_o   (s_sel_o),
        .s_dat_o   (s_dat_o),
        .s_dat_i   (s_dat_i),
        .s_ack_i   (s_ack_i),
        .s_err_i   (s_err_i)
    );

    function automatic logic [31:0] init_word(input int i);
        case (i)
            4:       return 32'hDEAD_BEEF;
            8:       return 32'hAAAA_AAAA;
            9:       return 32'hBBBB_BBBB;
            10:      return 32'hCCCC_CCCC;
            default: return 32'h5000_0000 | 32'(i);
        endcase
    endfunction

    // Single-cycle RAM: acks one edge after a strobe, drops ack the following cycle.
    assign s_ack_i = ack_q;
    assign s_err_i = err_q;
    assign s_dat_i = rdat_q;
    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < 64; i++) ram[i] <= init_word(i);
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            rdat_q <= '0;
        end else if (!rst_n) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            if (s_cyc_o && s_stb_o && !ack_q && !err_q) begin
                if (s_adr_o == BadAdr) begin
                    err_q <= 1'b1;
                end else if (ack_en) begin
                    ack_q  <= 1'b1;
                    rdat_q <= ram[s_adr_o[7:2]];
                    if (s_we_o) begin
                        for (int b = 0; b < 4; b++) begin
                            if (s_sel_o[b]) ram[s_adr_o[7:2]][8*b +: 8] <= s_dat_o[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic logic ack_of(input int m);
        return (m == 0) ? m0_ack_o : m1_ack_o;
    endfunction

    function automatic logic err_of(input int m);
        return (m == 0) ? m0_err_o : m1_err_o;
    endfunction

    function automatic logic [31:0] dat_of(input int m);
        return (m == 0) ? m0_dat_o : m1_dat_o;
    endfunction

    task automatic set_m(input int m, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
        if (m == 0) begin
            m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we;
            m0_adr_i = adr; m0_sel_i = sel; m0_dat_i = dat;
        end else begin
            m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we;
            m1_adr_i = adr; m1_sel_i = sel; m1_dat_i = dat;
        end
    endtask

    // One strobe; lat counts rising edges from driving the strobe to the termination.
    task automatic bus_op(input string nm, input int m, input logic we, input logic [31:0] adr,
                          input logic [3:0] sel, input logic [31:0] wdat, input logic keep_cyc,
                          output int lat, output logic got_err, output logic stb_end,
                          output logic other, output int end_cyc);
        logic [5:0]  idx;
        logic [31:0] exp_d;
        logic        pushed;
        idx = adr[7:2];
        lat = -1; got_err = 1'b0; stb_end = 1'b0; other = 1'b0; end_cyc = 0;
        exp_d = '0;
        @(posedge clk); #1;
        set_m(m, 1'b1, 1'b1, we, adr, sel, wdat);
        pushed = !we && (adr != BadAdr);
        if (pushed) begin
            if (m == 0) sb0.push_back(exp_mem[idx]);
            else        sb1.push_back(exp_mem[idx]);
        end
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (ack_of(1 - m) || err_of(1 - m)) other = 1'b1;
            if (ack_of(m) || err_of(m)) begin
                lat = n; got_err = err_of(m); stb_end = s_stb_o; end_cyc = cyc_cnt;
                break;
            end
        end
        if (pushed) exp_d = (m == 0) ? sb0.pop_front() : sb1.pop_front();
        if (lat < 0) begin
            n_assert++; n_fail++;
            $display("FAIL %s termination: got none within 40 cycles, required ack or err", nm);
        end else if (!got_err && pushed) begin
            n_assert++;
            if (dat_of(m) !== exp_d) begin
                n_fail++;
                $display("FAIL %s read data: got %h required %h", nm, dat_of(m), exp_d);
            end
        end else if (!got_err && we) begin
            for (int b = 0; b < 4; b++) if (sel[b]) exp_mem[idx][8*b +: 8] = wdat[8*b +: 8];
        end
        @(posedge clk); #1;
        set_m(m, keep_cyc, 1'b0, we, adr, sel, wdat);
    endtask

    task automatic do_race(input string nm, input int exp_w);
        int winner;
        logic [31:0] exp_d;
        winner = -1;
        @(posedge clk); #1;
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h10, 4'hF, '0);
        set_m(1, 1'b1, 1'b1, 1'b0, 32'h14, 4'hF, '0);
        sb0.push_back(exp_mem[4]);
        sb1.push_back(exp_mem[5]);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (m0_ack_o && m1_ack_o) winner = 2;
            else if (m0_ack_o)        winner = 0;
            else if (m1_ack_o)        winner = 1;
            if (winner >= 0) break;
        end
        n_assert++;
        if (winner != exp_w) begin
            n_fail++;
            $display("FAIL %s winner: got %0d required %0d", nm, winner, exp_w);
        end
        if (winner == 0 || winner == 1) begin
            exp_d = (winner == 0) ? sb0.pop_front() : sb1.pop_front();
            n_assert++;
            if (dat_of(winner) !== exp_d) begin
                n_fail++;
                $display("FAIL %s read data: got %h required %h", nm, dat_of(winner), exp_d);
            end
        end
        sb0.delete();
        sb1.delete();
        @(posedge clk); #1;
        set_m(0, 1'b0, 1'b0, 1'b0, 32'h10, 4'hF, '0);
        set_m(1, 1'b0, 1'b0, 1'b0, 32'h14, 4'hF, '0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ram_load = 1'b1; ack_en = 1'b1;
        for (int i = 0; i < 64; i++) exp_mem[i] = init_word(i);
        set_m(0, 1'b1, 1'b1, 1'b1, 32'h1234_5678, 4'h5, 32'hCAFE_F00D);
        set_m(1, 1'b1, 1'b1, 1'b0, 32'h8765_4321, 4'hA, 32'h0BAD_0BAD);
        @(posedge clk); @(posedge clk); #1;
        ram_load = 1'b0;
        @(negedge clk);
        n_assert++;
        if ({s_cyc_o, s_stb_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset controls: got %b required 000000",
                     {s_cyc_o, s_stb_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o});
        end
        n_assert++;
        if (s_adr_o !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL reset s_adr_o: got %h required 12345678", s_adr_o);
        end
        n_assert++;
        if ({s_we_o, s_sel_o, s_dat_o} !== {1'b1, 4'h5, 32'hCAFE_F00D}) begin
            n_fail++;
            $display("FAIL reset we/sel/dat: got %b/%h/%h required 1/5/cafef00d",
                     s_we_o, s_sel_o, s_dat_o);
        end
        set_m(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        set_m(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        rst_n = 1'b1;
        @(negedge clk);
        n_assert++;
        if (s_cyc_o !== 1'b0) begin
            n_fail++;
            $display("FAIL idle after reset s_cyc_o: got %b required 0", s_cyc_o);
        end
    endtask

    task automatic test_round_robin();
        for (int r = 0; r < 4; r++) do_race("round_robin", r % 2);
    endtask

    task automatic test_single();
        int lat, ec;
        logic er, se, oth;
        bus_op("single", 0, 1'b0, 32'h10, 4'hF, '0, 1'b0, lat, er, se, oth, ec);
        n_assert++;
        if (lat != 2 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL single latency/err: got %0d/%b required 2/0", lat, er);
        end
        n_assert++;
        if (oth !== 1'b0) begin
            n_fail++;
            $display("FAIL single m1 termination: got %b required 0", oth);
        end
    endtask

    task automatic test_held();
        int lat, ec0, ec1;
        logic er, se, o1, o2, o3, o0;
        logic [31:0] ram_now [3];
        fork
            begin
                bus_op("held_w0", 1, 1'b1, 32'h20, 4'b0011, 32'h1122_3344, 1'b1, lat, er, se, o1, ec1);
                bus_op("held_w1", 1, 1'b1, 32'h24, 4'b1100, 32'h5566_7788, 1'b1, lat, er, se, o2, ec1);
                bus_op("held_w2", 1, 1'b1, 32'h28, 4'b1111, 32'h99AA_BBCC, 1'b0, lat, er, se, o3, ec1);
            end
            begin
                repeat (2) @(posedge clk);
                bus_op("held_m0", 0, 1'b0, 32'h10, 4'hF, '0, 1'b0, lat, er, se, o0, ec0);
            end
        join
        n_assert++;
        if (ec0 <= ec1) begin
            n_fail++;
            $display("FAIL held m0 ack cycle: got %0d required after %0d", ec0, ec1);
        end
        n_assert++;
        if ({o1, o2, o3} !== 3'b000) begin
            n_fail++;
            $display("FAIL held m0 termination during m1 cycle: got %b required 000", {o1, o2, o3});
        end
        ram_now[0] = ram[8]; ram_now[1] = ram[9]; ram_now[2] = ram[10];
        n_assert++;
        if ({ram_now[0], ram_now[1], ram_now[2]} !== {32'hAAAA_3344, 32'h5566_BBBB, 32'h99AA_BBCC}) begin
            n_fail++;
            $display("FAIL held ram bytes: got %h %h %h required aaaa3344 5566bbbb 99aabbcc",
                     ram_now[0], ram_now[1], ram_now[2]);
        end
        for (int a = 0; a < 3; a++) begin
            bus_op("held_readback", 0, 1'b0, 32'h20 + 32'(4 * a), 4'hF, '0, 1'b0, lat, er, se, o0, ec0);
        end
    endtask

    task automatic test_watchdog();
        int lat, ec;
        logic er, se, oth;
        ack_en = 1'b0;
        bus_op("watchdog", 0, 1'b0, 32'h10, 4'hF, '0, 1'b0, lat, er, se, oth, ec);
        ack_en = 1'b1;
        n_assert++;
        if (lat != 5 || er !== 1'b1) begin
            n_fail++;
            $display("FAIL watchdog err timing: got %0d/%b required 5/1", lat, er);
        end
        n_assert++;
        if (se !== 1'b0) begin
            n_fail++;
            $display("FAIL watchdog s_stb_o in err cycle: got %b required 0", se);
        end
        bus_op("after_watchdog", 0, 1'b0, 32'h14, 4'hF, '0, 1'b0, lat, er, se, oth, ec);
        n_assert++;
        if (lat != 2 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL after_watchdog latency/err: got %0d/%b required 2/0", lat, er);
        end
    endtask

    task automatic test_oob();
        int lat, ec;
        logic er, se, oth;
        bus_op("oob", 1, 1'b0, BadAdr, 4'hF, '0, 1'b1, lat, er, se, oth, ec);
        n_assert++;
        if (lat != 2 || er !== 1'b1) begin
            n_fail++;
            $display("FAIL oob err: got %0d/%b required 2/1", lat, er);
        end
        @(negedge clk);
        n_assert++;
        if (m1_err_o !== 1'b0 || s_cyc_o !== 1'b1) begin
            n_fail++;
            $display("FAIL oob after err m1_err_o/s_cyc_o: got %b/%b required 0/1", m1_err_o, s_cyc_o);
        end
        @(posedge clk); #1;
        set_m(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        bus_op("after_oob", 0, 1'b0, 32'h10, 4'hF, '0, 1'b0, lat, er, se, oth, ec);
        n_assert++;
        if (lat != 2 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL after_oob latency/err: got %0d/%b required 2/0", lat, er);
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        seen = 1'b0;
        @(posedge clk); #1;
        set_m(0, 1'b0, 1'b0, 1'b0, 32'h0000_0ABC, 4'h0, '0);
        set_m(1, 1'b1, 1'b1, 1'b0, 32'h14, 4'hF, '0);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (m1_ack_o) begin
                seen = 1'b1;
                break;
            end
        end
        n_assert++;
        if (seen !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid m1 ack before reset: got %b required 1", seen);
        end
        #2 rst_n = 1'b0;
        #1;
        n_assert++;
        if ({s_cyc_o, s_stb_o, m1_ack_o, m1_err_o} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_mid controls: got %b required 0000",
                     {s_cyc_o, s_stb_o, m1_ack_o, m1_err_o});
        end
        n_assert++;
        if (s_adr_o !== 32'h0000_0ABC) begin
            n_fail++;
            $display("FAIL reset_mid s_adr_o: got %h required 00000abc", s_adr_o);
        end
        @(posedge clk); #1;
        set_m(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        rst_n = 1'b1;
        do_race("tie_after_reset", 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish by 200000 required finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_held();
        test_watchdog();
        test_oob();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
